pupil_centroid: RTL and testbench

//  Per-frame dark-blob (pupil) centroid on the Camera Link dual-tap stream. Sits beside CLctrl behind
//  INP_CAMERA_DATA (CCLK domain), thresholds each pixel, accumulates count/sum_x/sum_y and divides at

---
 rtl/eyetracker_pkg.sv | 17 +
 rtl/seq_udiv.sv | 88 ++++++++
 rtl/pupil_centroid.sv | 255 +++++++++++++++++++++++++
 tb/tb_pupil_centroid.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eyetracker_pkg.sv
// Shared eyetracker definitions: centroid FSM state encoding and default frame geometry.
package eyetracker_pkg;

    localparam int PIX_HACT_DEF = 640;
    localparam int PIX_VACT_DEF = 480;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_DIV_X = 3'd2;
    localparam logic [2:0] ST_DIV_Y = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic logic is_busy_state(input logic [2:0] state);
        return (state == ST_DIV_X) || (state == ST_DIV_Y) || (state == ST_DONE);
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider producing one quotient bit per cycle.
// The first bit is resolved on the iSTART edge, so oDONE pulses DIVIDEND_WIDTH cycles after iSTART.
module seq_udiv
    import eyetracker_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 29,
    parameter int DIVISOR_WIDTH  = 19,
    parameter int QUOTIENT_WIDTH = 10
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      iSTART,
    input  logic [DIVIDEND_WIDTH-1:0] iDIVIDEND,
    input  logic [DIVISOR_WIDTH-1:0]  iDIVISOR,
    output logic [QUOTIENT_WIDTH-1:0] oQUOTIENT,
    output logic                      oDONE
);

    localparam int STEP_W = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d, src_rem;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d, src_quo;
    logic [DIVISOR_WIDTH-1:0]  div_q, div_d, src_div;
    logic [STEP_W-1:0]         steps_q, steps_d;
    logic                      run_q, run_d;
    logic                      done_q, done_d;
    logic [DIVISOR_WIDTH:0]    shifted, diff;

    always_comb begin
        src_rem = iSTART ? '0 : rem_q;
        src_quo = iSTART ? iDIVIDEND : quo_q;
        src_div = iSTART ? iDIVISOR : div_q;
        shifted = {src_rem, src_quo[DIVIDEND_WIDTH-1]};
        diff    = shifted - {1'b0, src_div};

        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        steps_d = steps_q;
        run_d   = run_q;
        done_d  = 1'b0;

        if (iSTART || run_q) begin
            div_d = src_div;
            // Remainder stays below the divisor, so it always fits DIVISOR_WIDTH bits.
            if (!diff[DIVISOR_WIDTH]) begin
                rem_d = diff[DIVISOR_WIDTH-1:0];
                quo_d = {src_quo[DIVIDEND_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[DIVISOR_WIDTH-1:0];
                quo_d = {src_quo[DIVIDEND_WIDTH-2:0], 1'b0};
            end
        end

        if (iSTART) begin
            steps_d = STEP_W'(DIVIDEND_WIDTH - 1);
            run_d   = 1'b1;
        end else if (run_q) begin
            steps_d = steps_q - 1'b1;
            if (steps_q == STEP_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            steps_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

    assign oQUOTIENT = quo_q[QUOTIENT_WIDTH-1:0];
    assign oDONE     = done_q;

endmodule

// File: rtl/pupil_centroid.sv
// Per-frame dark-pixel (pupil) centroid on a dual-tap camera stream, divided at frame end.
// Optional region-of-interest gating is compiled in with `define PUPIL_CENTROID_ROI_EN.
module pupil_centroid
    import eyetracker_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int PIX_HACT    = PIX_HACT_DEF,
    parameter int PIX_VACT    = PIX_VACT_DEF,
    parameter int CNT_WIDTH   = 19,
    parameter int SUM_WIDTH   = 29
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   iFVAL,
    input  logic                   iLVAL,
    input  logic                   iDVAL,
    input  logic [PIXEL_WIDTH-1:0] iDATA_L,
    input  logic [PIXEL_WIDTH-1:0] iDATA_R,
    input  logic [PIXEL_WIDTH-1:0] iTHRESHOLD,
`ifdef PUPIL_CENTROID_ROI_EN
    input  logic [ADDR_WIDTH-1:0]  iROI_X0,
    input  logic [ADDR_WIDTH-1:0]  iROI_X1,
    input  logic [ADDR_WIDTH-1:0]  iROI_Y0,
    input  logic [ADDR_WIDTH-1:0]  iROI_Y1,
`endif
    output logic [ADDR_WIDTH-1:0]  oPOINT_X,
    output logic [ADDR_WIDTH-1:0]  oPOINT_Y,
    output logic [CNT_WIDTH-1:0]   oPIX_COUNT,
    output logic                   oVALID,
    output logic                   oNO_TARGET,
    output logic                   oBUSY
);

    localparam logic [ADDR_WIDTH-1:0] HACT = ADDR_WIDTH'(PIX_HACT);
    localparam logic [ADDR_WIDTH-1:0] VACT = ADDR_WIDTH'(PIX_VACT);

    logic                   fval_r_q, fval_r_d, lval_r_q, lval_r_d, dval_r_q, dval_r_d;
    logic                   fval_p_q, fval_p_d, lval_p_q, lval_p_d;
    logic [PIXEL_WIDTH-1:0] data_l_q, data_l_d, data_r_q, data_r_d, thr_q, thr_d;
    logic                   fval_rise, fval_fall, lval_rise, lval_fall;

    logic [2:0]             state_q, state_d;
    logic                   frame_q, frame_d;
    logic [ADDR_WIDTH-1:0]  x_q, x_d, y_q, y_d, x_eff, x_odd, y_eff;
    logic [CNT_WIDTH-1:0]   count_q, count_d, lat_cnt_q, lat_cnt_d;
    logic [SUM_WIDTH-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d, lat_sum_y_q, lat_sum_y_d;
    logic [ADDR_WIDTH-1:0]  quo_x_q, quo_x_d;
    logic                   accum, dl, dr, roi_l, roi_r;

    logic [ADDR_WIDTH-1:0]  point_x_q, point_x_d, point_y_q, point_y_d;
    logic [CNT_WIDTH-1:0]   pix_count_q, pix_count_d;
    logic                   valid_q, valid_d, no_target_q, no_target_d;

    logic                   div_start, div_done;
    logic [SUM_WIDTH-1:0]   div_dividend;
    logic [CNT_WIDTH-1:0]   div_divisor;
    logic [ADDR_WIDTH-1:0]  div_quo;

`ifdef PUPIL_CENTROID_ROI_EN
    logic [ADDR_WIDTH-1:0]  roi_x0_q, roi_x0_d, roi_x1_q, roi_x1_d;
    logic [ADDR_WIDTH-1:0]  roi_y0_q, roi_y0_d, roi_y1_q, roi_y1_d;
`endif

    always_comb begin
        fval_r_d = iFVAL;
        lval_r_d = iLVAL;
        dval_r_d = iDVAL;
        data_l_d = iDATA_L;
        data_r_d = iDATA_R;
        thr_d    = iTHRESHOLD;
        fval_p_d = fval_r_q;
        lval_p_d = lval_r_q;
    end

    assign fval_rise = fval_r_q & ~fval_p_q;
    assign fval_fall = ~fval_r_q & fval_p_q;
    assign lval_rise = lval_r_q & ~lval_p_q;
    assign lval_fall = ~lval_r_q & lval_p_q;

    // Frame-start and line-start clears are folded into the same cycle's accumulation.
    always_comb begin
        x_eff = lval_rise ? '0 : x_q;
        x_odd = x_eff + 1'b1;
        y_eff = fval_rise ? '0 : y_q;
        accum = (frame_q | fval_rise) & fval_r_q & lval_r_q & dval_r_q;

`ifdef PUPIL_CENTROID_ROI_EN
        roi_x0_d = fval_rise ? iROI_X0 : roi_x0_q;
        roi_x1_d = fval_rise ? iROI_X1 : roi_x1_q;
        roi_y0_d = fval_rise ? iROI_Y0 : roi_y0_q;
        roi_y1_d = fval_rise ? iROI_Y1 : roi_y1_q;
        roi_l = (x_eff >= roi_x0_q) && (x_eff <= roi_x1_q) && (y_eff >= roi_y0_q) && (y_eff <= roi_y1_q);
        roi_r = (x_odd >= roi_x0_q) && (x_odd <= roi_x1_q) && (y_eff >= roi_y0_q) && (y_eff <= roi_y1_q);
`else
        roi_l = 1'b1;
        roi_r = 1'b1;
`endif

        dl = accum && (data_l_q < thr_q) && (x_eff < HACT) && (y_eff < VACT) && roi_l;
        dr = accum && (data_r_q < thr_q) && (x_odd < HACT) && (y_eff < VACT) && roi_r;

        count_d = (fval_rise ? '0 : count_q) + CNT_WIDTH'(dl) + CNT_WIDTH'(dr);
        sum_x_d = (fval_rise ? '0 : sum_x_q) + (dl ? SUM_WIDTH'(x_eff) : '0) + (dr ? SUM_WIDTH'(x_odd) : '0);
        sum_y_d = (fval_rise ? '0 : sum_y_q) + (dl ? SUM_WIDTH'(y_eff) : '0) + (dr ? SUM_WIDTH'(y_eff) : '0);

        // x parks at the line end so over-long lines cannot wrap back into the active area.
        x_d = x_eff;
        if (accum && (x_eff < HACT)) x_d = x_eff + ADDR_WIDTH'(2);
        y_d = y_eff;
        if (lval_fall && (y_eff < VACT)) y_d = y_eff + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        lat_cnt_d    = lat_cnt_q;
        lat_sum_y_d  = lat_sum_y_q;
        quo_x_d      = quo_x_q;
        point_x_d    = point_x_q;
        point_y_d    = point_y_q;
        pix_count_d  = pix_count_q;
        valid_d      = 1'b0;
        no_target_d  = 1'b0;
        div_start    = 1'b0;
        div_dividend = sum_x_q;
        div_divisor  = count_q;

        if (fval_rise) begin
            frame_d = 1'b1;
            if (state_q == ST_IDLE) state_d = ST_ACCUM;
        end

        // A frame that ends while the divider is still busy is silently dropped.
        if (fval_fall) begin
            frame_d = 1'b0;
            if (state_q == ST_ACCUM) begin
                pix_count_d = count_q;
                if (count_q == '0) begin
                    no_target_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    lat_cnt_d   = count_q;
                    lat_sum_y_d = sum_y_q;
                    div_start   = 1'b1;
                    state_d     = ST_DIV_X;
                end
            end
        end

        case (state_q)
            ST_DIV_X: if (div_done) begin
                quo_x_d      = div_quo;
                div_start    = 1'b1;
                div_dividend = lat_sum_y_q;
                div_divisor  = lat_cnt_q;
                state_d      = ST_DIV_Y;
            end
            ST_DIV_Y: if (div_done) state_d = ST_DONE;
            ST_DONE: begin
                point_x_d = quo_x_q;
                point_y_d = div_quo;
                valid_d   = 1'b1;
                state_d   = frame_d ? ST_ACCUM : ST_IDLE;
            end
            default: ;
        endcase
    end

    seq_udiv #(
        .DIVIDEND_WIDTH(SUM_WIDTH),
        .DIVISOR_WIDTH (CNT_WIDTH),
        .QUOTIENT_WIDTH(ADDR_WIDTH)
    ) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .iSTART   (div_start),
        .iDIVIDEND(div_dividend),
        .iDIVISOR (div_divisor),
        .oQUOTIENT(div_quo),
        .oDONE    (div_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fval_r_q    <= 1'b0;
            lval_r_q    <= 1'b0;
            dval_r_q    <= 1'b0;
            fval_p_q    <= 1'b0;
            lval_p_q    <= 1'b0;
            data_l_q    <= '0;
            data_r_q    <= '0;
            thr_q       <= '0;
            state_q     <= ST_IDLE;
            frame_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            count_q     <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            lat_cnt_q   <= '0;
            lat_sum_y_q <= '0;
            quo_x_q     <= '0;
            point_x_q   <= '0;
            point_y_q   <= '0;
            pix_count_q <= '0;
            valid_q     <= 1'b0;
            no_target_q <= 1'b0;
`ifdef PUPIL_CENTROID_ROI_EN
            roi_x0_q    <= '0;
            roi_x1_q    <= '0;
            roi_y0_q    <= '0;
            roi_y1_q    <= '0;
`endif
        end else begin
            fval_r_q    <= fval_r_d;
            lval_r_q    <= lval_r_d;
            dval_r_q    <= dval_r_d;
            fval_p_q    <= fval_p_d;
            lval_p_q    <= lval_p_d;
            data_l_q    <= data_l_d;
            data_r_q    <= data_r_d;
            thr_q       <= thr_d;
            state_q     <= state_d;
            frame_q     <= frame_d;
            x_q         <= x_d;
            y_q         <= y_d;
            count_q     <= count_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            lat_cnt_q   <= lat_cnt_d;
            lat_sum_y_q <= lat_sum_y_d;
            quo_x_q     <= quo_x_d;
            point_x_q   <= point_x_d;
            point_y_q   <= point_y_d;
            pix_count_q <= pix_count_d;
            valid_q     <= valid_d;
            no_target_q <= no_target_d;
`ifdef PUPIL_CENTROID_ROI_EN
            roi_x0_q    <= roi_x0_d;
            roi_x1_q    <= roi_x1_d;
            roi_y0_q    <= roi_y0_d;
            roi_y1_q    <= roi_y1_d;
`endif
        end
    end

    assign oPOINT_X   = point_x_q;
    assign oPOINT_Y   = point_y_q;
    assign oPIX_COUNT = pix_count_q;
    assign oVALID     = valid_q;
    assign oNO_TARGET = no_target_q;
    assign oBUSY      = is_busy_state(state_q);

endmodule

// File: tb/tb_pupil_centroid.sv
// Directed bench for pupil_centroid: hand-computed centroids, pulse timing, reset and busy-frame handling.
module tb_pupil_centroid;

    localparam int         SW  = 29;
    // One input-register cycle plus 2*SW+2 cycles from fall detection to oVALID.
    localparam int         LAT = 2 * SW + 3;
    localparam logic [7:0] THR = 8'h40;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iFVAL, iLVAL, iDVAL;
    logic [7:0]  iDATA_L, iDATA_R, iTHRESHOLD;
    logic [9:0]  oPOINT_X, oPOINT_Y;
    logic [18:0] oPIX_COUNT;
    logic        oVALID, oNO_TARGET, oBUSY;
`ifdef PUPIL_CENTROID_ROI_EN
    logic [9:0]  iROI_X0, iROI_X1, iROI_Y0, iROI_Y1;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;
    int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1, ex, ey;

    always #5 CLK = ~CLK;

    pupil_centroid dut (
        .CLK       (CLK),
        .RST       (RST),
        .iFVAL     (iFVAL),
        .iLVAL     (iLVAL),
        .iDVAL     (iDVAL),
        .iDATA_L   (iDATA_L),
        .iDATA_R   (iDATA_R),
        .iTHRESHOLD(iTHRESHOLD),
`ifdef PUPIL_CENTROID_ROI_EN
        .iROI_X0   (iROI_X0),
        .iROI_X1   (iROI_X1),
        .iROI_Y0   (iROI_Y0),
        .iROI_Y1   (iROI_Y1),
`endif
        .oPOINT_X  (oPOINT_X),
        .oPOINT_Y  (oPOINT_Y),
        .oPIX_COUNT(oPIX_COUNT),
        .oVALID    (oVALID),
        .oNO_TARGET(oNO_TARGET),
        .oBUSY     (oBUSY)
    );

    task automatic clear_pattern();
        ax0 = 0; ax1 = -1; ay0 = 0; ay1 = -1;
        bx0 = 0; bx1 = -1; by0 = 0; by1 = -1;
        ex = -1; ey = -1;
    endtask

    function automatic logic [7:0] pix(input int x, input int y);
        if ((x >= ax0 && x <= ax1 && y >= ay0 && y <= ay1) ||
            (x >= bx0 && x <= bx1 && y >= by0 && y <= by1)) return 8'h10;
        if (x == ex && y == ey) return THR;
        return 8'hFF;
    endfunction

    function automatic int line_max_x(input int y);
        int m = -1;
        if (y >= ay0 && y <= ay1 && ax1 > m) m = ax1;
        if (y >= by0 && y <= by1 && bx1 > m) m = bx1;
        if (y == ey && ex > m) m = ex;
        return m;
    endfunction

    // Lines without dark pixels are shortened to one beat; ends with iFVAL dropped on a negedge.
    task automatic send_frame(input int nlines, input int tail_idle);
        @(negedge CLK);
        iFVAL = 1'b1;
        repeat (2) @(negedge CLK);
        for (int y = 0; y < nlines; y++) begin
            int m = line_max_x(y);
            int beats = (m < 0) ? 1 : (m / 2 + 1);
            for (int k = 0; k < beats; k++) begin
                iLVAL = 1'b1; iDVAL = 1'b1;
                iDATA_L = pix(2 * k, y);
                iDATA_R = pix(2 * k + 1, y);
                @(negedge CLK);
            end
            iLVAL = 1'b0; iDVAL = 1'b0; iDATA_L = 8'hFF; iDATA_R = 8'hFF;
            repeat (2) @(negedge CLK);
        end
        repeat (tail_idle) @(negedge CLK);
        iFVAL = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic v, output logic nt);
        lat = 0; v = 1'b0; nt = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge CLK);
            if (oVALID || oNO_TARGET) begin
                lat = n; v = oVALID; nt = oNO_TARGET;
                return;
            end
        end
    endtask

    task automatic expect_point(input string name, input int lat, input int exp_lat,
                                input int ex_x, input int ex_y, input int ex_cnt);
        n_compared++; if (lat != exp_lat) begin n_mismatched++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        n_compared++; if (oPOINT_X !== 10'(ex_x)) begin n_mismatched++; $display("[TB] FAIL %s_x: got %0d expected %0d", name, oPOINT_X, ex_x); end
        n_compared++; if (oPOINT_Y !== 10'(ex_y)) begin n_mismatched++; $display("[TB] FAIL %s_y: got %0d expected %0d", name, oPOINT_Y, ex_y); end
        n_compared++; if (oPIX_COUNT !== 19'(ex_cnt)) begin n_mismatched++; $display("[TB] FAIL %s_count: got %0d expected %0d", name, oPIX_COUNT, ex_cnt); end
    endtask

    task automatic test_reset();
        RST = 1'b1; iFVAL = 1'b0; iLVAL = 1'b0; iDVAL = 1'b0;
        iDATA_L = 8'hFF; iDATA_R = 8'hFF; iTHRESHOLD = THR;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_compared++; if ({oPOINT_X, oPOINT_Y} !== 20'd0) begin n_mismatched++; $display("[TB] FAIL reset_point: got %0d,%0d expected 0,0", oPOINT_X, oPOINT_Y); end
        n_compared++; if (oPIX_COUNT !== 19'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", oPIX_COUNT); end
        n_compared++; if ({oVALID, oNO_TARGET, oBUSY} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {oVALID, oNO_TARGET, oBUSY}); end
    endtask

    task automatic test_single_pixel();
        int lat; logic v, nt;
        clear_pattern(); ax0 = 100; ax1 = 100; ay0 = 50; ay1 = 50;
        send_frame(51, 0);
        wait_result(lat, v, nt);
        n_compared++; if ({v, nt} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL single_pulses: got valid=%b no_target=%b expected 1 0", v, nt); end
        expect_point("single", lat, LAT, 100, 50, 1);
        @(negedge CLK);
        n_compared++; if (oVALID !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_valid_width: got %b expected 0", oVALID); end
    endtask

    task automatic test_odd_tap();
        int lat; logic v, nt;
        clear_pattern(); ax0 = 101; ax1 = 101; ay0 = 7; ay1 = 7;
        send_frame(8, 0);
        wait_result(lat, v, nt);
        n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL odd_valid: got %b expected 1", v); end
        expect_point("odd", lat, LAT, 101, 7, 1);
    endtask

    task automatic test_block();
        int lat; logic v, nt;
        clear_pattern(); ax0 = 200; ax1 = 209; ay0 = 300; ay1 = 309;
        send_frame(310, 0);
        wait_result(lat, v, nt);
        n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL block_valid: got %b expected 1", v); end
        expect_point("block", lat, LAT, 204, 304, 100);
    endtask

    task automatic test_no_target();
        int lat, spurious; logic v, nt;
        clear_pattern();
        send_frame(4, 0);
        wait_result(lat, v, nt);
        n_compared++; if ({v, nt} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL empty_pulses: got valid=%b no_target=%b expected 0 1", v, nt); end
        expect_point("empty", lat, 2, 204, 304, 0);
        spurious = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (oVALID || oNO_TARGET || oBUSY) spurious++;
        end
        n_compared++; if (spurious != 0) begin n_mismatched++; $display("[TB] FAIL empty_quiet: got %0d active cycles expected 0", spurious); end
    endtask

    // Pixel equal to threshold is not dark; pixels at x>=640 are outside the active line.
    task automatic test_threshold_edge();
        int lat; logic v, nt;
        clear_pattern(); ax0 = 4; ax1 = 4; ay0 = 2; ay1 = 2;
        bx0 = 640; bx1 = 645; by0 = 2; by1 = 2; ex = 6; ey = 2;
        send_frame(3, 0);
        wait_result(lat, v, nt);
        n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL edge_valid: got %b expected 1", v); end
        expect_point("edge", lat, LAT, 4, 2, 1);
    endtask

    task automatic test_reset_mid_div();
        int lat; logic v, nt;
        clear_pattern(); ax0 = 100; ax1 = 100; ay0 = 50; ay1 = 50;
        send_frame(51, 0);
        repeat (10) @(negedge CLK);
        n_compared++; if (oBUSY !== 1'b1) begin n_mismatched++; $display("[TB] FAIL middiv_busy: got %b expected 1", oBUSY); end
        RST = 1'b1;
        #1;
        n_compared++; if ({oPOINT_X, oPOINT_Y} !== 20'd0) begin n_mismatched++; $display("[TB] FAIL middiv_point: got %0d,%0d expected 0,0", oPOINT_X, oPOINT_Y); end
        n_compared++; if ({oPIX_COUNT, oVALID, oNO_TARGET, oBUSY} !== 22'd0) begin n_mismatched++; $display("[TB] FAIL middiv_outputs: got count=%0d flags=%b expected 0 000", oPIX_COUNT, {oVALID, oNO_TARGET, oBUSY}); end
        @(negedge CLK);
        RST = 1'b0;
        clear_pattern(); ax0 = 12; ax1 = 13; ay0 = 14; ay1 = 15;
        send_frame(16, 0);
        wait_result(lat, v, nt);
        n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL after_reset_valid: got %b expected 1", v); end
        expect_point("after_reset", lat, LAT, 12, 14, 4);
    endtask

    task automatic test_busy_drop();
        int lat, spurious; logic v, nt;
        clear_pattern(); ax0 = 100; ax1 = 100; ay0 = 50; ay1 = 50;
        send_frame(51, 0);
        clear_pattern(); ax0 = 2; ax1 = 3; ay0 = 1; ay1 = 1;
        send_frame(2, 0);
        wait_result(lat, v, nt);
        n_compared++; if ({v, nt} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL drop_pulses: got valid=%b no_target=%b expected 1 0", v, nt); end
        n_compared++; if ({oPOINT_X, oPOINT_Y} !== {10'd100, 10'd50}) begin n_mismatched++; $display("[TB] FAIL drop_point: got %0d,%0d expected 100,50", oPOINT_X, oPOINT_Y); end
        spurious = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (oVALID || oNO_TARGET) spurious++;
        end
        n_compared++; if (spurious != 0) begin n_mismatched++; $display("[TB] FAIL drop_quiet: got %0d pulses expected 0", spurious); end
        n_compared++; if (oPIX_COUNT !== 19'd1) begin n_mismatched++; $display("[TB] FAIL drop_count: got %0d expected 1", oPIX_COUNT); end
    endtask

    task automatic test_back_to_back();
        int lat; logic v, nt;
        clear_pattern(); ax0 = 100; ax1 = 100; ay0 = 50; ay1 = 50;
        send_frame(51, 0);
        clear_pattern(); ax0 = 6; ax1 = 6; ay0 = 3; ay1 = 3;
        send_frame(4, 80);
        wait_result(lat, v, nt);
        n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_valid: got %b expected 1", v); end
        expect_point("b2b", lat, LAT, 6, 3, 1);
    endtask

`ifdef PUPIL_CENTROID_ROI_EN
    task automatic test_roi();
        int lat; logic v, nt;
        iROI_X0 = 10'd0; iROI_X1 = 10'd99; iROI_Y0 = 10'd0; iROI_Y1 = 10'd99;
        clear_pattern(); ax0 = 150; ax1 = 150; ay0 = 150; ay1 = 150;
        bx0 = 10; bx1 = 10; by0 = 20; by1 = 20;
        send_frame(151, 0);
        wait_result(lat, v, nt);
        n_compared++; if (v !== 1'b1) begin n_mismatched++; $display("[TB] FAIL roi_valid: got %b expected 1", v); end
        expect_point("roi", lat, LAT, 10, 20, 1);
    endtask
`endif

    initial begin
`ifdef PUPIL_CENTROID_ROI_EN
        iROI_X0 = 10'd0; iROI_X1 = 10'd1023; iROI_Y0 = 10'd0; iROI_Y1 = 10'd1023;
`endif
        test_reset();
        test_single_pixel();
        test_odd_tap();
        test_block();
        test_no_target();
        test_threshold_edge();
        test_reset_mid_div();
        test_busy_drop();
        test_back_to_back();
`ifdef PUPIL_CENTROID_ROI_EN
        test_roi();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
